// File: rtl/spi_bus_arbiter.sv
// Round-robin owner arbitration for the shared board SPI bus, with chip-select gating
// and an idle guard gap between owners. Define ARB_TIMEOUT_EN to bound each grant.
module spi_bus_arbiter #(
  parameter int unsigned NREQ           = 3,
  parameter int unsigned GAP_CYCLES     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic            clk,
  input  logic            enable,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] gnt,
  input  logic [NREQ-1:0] m_sck,
  input  logic [NREQ-1:0] m_mosi,
  input  logic [NREQ-1:0] m_cs_n,
  output logic            spi_sck,
  output logic            spi_mosi,
  output logic [NREQ-1:0] cs_n,
  input  logic            spi_miso,
  output logic [NREQ-1:0] m_miso,
  output logic            busy,
  output logic [2:0]      owner,
  output logic            timeout_err
);

  localparam int unsigned GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [NREQ-1:0] OneHot0 = NREQ'(1);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StOwn  = 2'd1;
  localparam logic [1:0] StGap  = 2'd2;

  if (NREQ < 2 || NREQ > 8 || GAP_CYCLES < 1 || TIMEOUT_CYCLES < 2 || TW > 32) begin : g_param_err
    $error("spi_bus_arbiter: illegal parameter value");
  end

  logic [1:0]      state_q, state_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [2:0]      owner_q, owner_d;
  logic [GW-1:0]   gap_cnt_q, gap_cnt_d;
  logic [NREQ-1:0] req_eff;
  logic [2:0]      pick_idx;

  // First requester found scanning upward from the slot after the last owner.
  function automatic logic [2:0] rr_pick(input logic [2:0] last, input logic [NREQ-1:0] r);
    logic [2:0]      sel;
    logic [NREQ-1:0] sh;
    int unsigned     idx;
    sel = last;
    for (int unsigned k = NREQ; k >= 1; k--) begin
      idx = ({29'd0, last} + k) % NREQ;
      sh  = r >> idx;
      if (sh[0]) begin
        sel = 3'(idx);
      end
    end
    return sel;
  endfunction

`ifdef ARB_TIMEOUT_EN
  logic [TW-1:0]   to_cnt_q, to_cnt_d;
  logic [NREQ-1:0] mask_q, mask_d;
  logic            timeout_err_q, timeout_err_d;

  // A revoked master stays masked until its req has been sampled low once.
  assign req_eff     = req & ~mask_q;
  assign timeout_err = timeout_err_q;
`else
  assign req_eff     = req;
  assign timeout_err = 1'b0;
`endif

  assign pick_idx = rr_pick(owner_q, req_eff);

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    owner_d   = owner_q;
    gap_cnt_d = gap_cnt_q;
`ifdef ARB_TIMEOUT_EN
    to_cnt_d      = to_cnt_q;
    mask_d        = mask_q & req;
    timeout_err_d = timeout_err_q;
`endif
    case (state_q)
      StIdle: begin
        if (|req_eff) begin
          gnt_d   = OneHot0 << pick_idx;
          owner_d = pick_idx;
          state_d = StOwn;
`ifdef ARB_TIMEOUT_EN
          to_cnt_d = '0;
`endif
        end
      end
      StOwn: begin
        if (!(|(gnt_q & req))) begin
          gnt_d     = '0;
          gap_cnt_d = '0;
          state_d   = StGap;
        end
`ifdef ARB_TIMEOUT_EN
        else if (to_cnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
          gnt_d         = '0;
          gap_cnt_d     = '0;
          state_d       = StGap;
          timeout_err_d = 1'b1;
          mask_d        = (mask_q & req) | gnt_q;
        end else begin
          to_cnt_d = to_cnt_q + TW'(1);
        end
`endif
      end
      StGap: begin
        gap_cnt_d = gap_cnt_q + GW'(1);
        if (gap_cnt_q == GW'(GAP_CYCLES - 1)) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
        gnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge enable) begin
    if (enable) begin
      state_q   <= StIdle;
      gnt_q     <= '0;
      owner_q   <= 3'(NREQ - 1);
      gap_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      owner_q   <= owner_d;
      gap_cnt_q <= gap_cnt_d;
    end
  end

`ifdef ARB_TIMEOUT_EN
  always_ff @(posedge clk or posedge enable) begin
    if (enable) begin
      to_cnt_q      <= '0;
      mask_q        <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      to_cnt_q      <= to_cnt_d;
      mask_q        <= mask_d;
      timeout_err_q <= timeout_err_d;
    end
  end
`endif

  // Grant is one-hot, so AND-OR muxing selects exactly the owner's lines.
  assign gnt      = gnt_q;
  assign busy     = |gnt_q;
  assign owner    = owner_q;
  assign spi_sck  = |(gnt_q & m_sck);
  assign spi_mosi = |(gnt_q & m_mosi);
  assign cs_n     = m_cs_n | ~gnt_q;
  assign m_miso   = gnt_q & {NREQ{spi_miso}};

endmodule

// File: tb/tb_spi_bus_arbiter.sv
// Directed bench for spi_bus_arbiter: reset, grant latency, round-robin order, guard gap,
// no pre-emption, chip-select gating, async reset mid-frame and the grant timeout.
module tb_spi_bus_arbiter;

  localparam int unsigned NREQ    = 3;
  localparam int unsigned GAP     = 4;
  localparam int unsigned TIMEOUT = 16;

  logic            clk = 1'b0;
  logic            enable = 1'b0;
  logic [NREQ-1:0] req = '0;
  logic [NREQ-1:0] gnt;
  logic [NREQ-1:0] m_sck = '0;
  logic [NREQ-1:0] m_mosi = '0;
  logic [NREQ-1:0] m_cs_n = '1;
  logic            spi_sck;
  logic            spi_mosi;
  logic [NREQ-1:0] cs_n;
  logic            spi_miso = 1'b0;
  logic [NREQ-1:0] m_miso;
  logic            busy;
  logic [2:0]      owner;
  logic            timeout_err;

  int n_vec = 0;
  int n_err = 0;

  spi_bus_arbiter #(
    .NREQ          (NREQ),
    .GAP_CYCLES    (GAP),
    .TIMEOUT_CYCLES(TIMEOUT)
  ) dut (
    .clk        (clk),
    .enable     (enable),
    .req        (req),
    .gnt        (gnt),
    .m_sck      (m_sck),
    .m_mosi     (m_mosi),
    .m_cs_n     (m_cs_n),
    .spi_sck    (spi_sck),
    .spi_mosi   (spi_mosi),
    .cs_n       (cs_n),
    .spi_miso   (spi_miso),
    .m_miso     (m_miso),
    .busy       (busy),
    .owner      (owner),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic pulse_reset;
    @(negedge clk);
    enable = 1'b1;
    @(negedge clk);
    enable = 1'b0;
  endtask

  task automatic idle_wait;
    req = '0;
    repeat (GAP + 3) @(negedge clk);
  endtask

  task automatic test_reset;
    @(negedge clk);
    enable   = 1'b1;
    spi_miso = 1'b1;
    m_sck    = '1;
    m_cs_n   = '0;
    #1;
    n_vec++; if (gnt !== 3'b000) begin n_err++; $display("FAIL reset_gnt: got %b want 000", gnt); end
    n_vec++; if (owner !== 3'd2) begin n_err++; $display("FAIL reset_owner: got %0d want 2", owner); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_vec++; if (cs_n !== 3'b111) begin n_err++; $display("FAIL reset_cs_n: got %b want 111", cs_n); end
    n_vec++; if (spi_sck !== 1'b0) begin n_err++; $display("FAIL reset_sck: got %b want 0", spi_sck); end
    n_vec++; if (m_miso !== 3'b000) begin n_err++; $display("FAIL reset_miso: got %b want 000", m_miso); end
    n_vec++; if (timeout_err !== 1'b0) begin n_err++; $display("FAIL reset_terr: got %b want 0", timeout_err); end
    @(negedge clk);
    enable = 1'b0;
    m_sck  = '0;
    m_cs_n = '1;
  endtask

  task automatic test_single_grant;
    req      = 3'b010;
    m_cs_n   = 3'b101;
    m_mosi   = 3'b010;
    spi_miso = 1'b1;
    @(negedge clk);
    n_vec++; if (gnt !== 3'b010) begin n_err++; $display("FAIL single_gnt: got %b want 010", gnt); end
    n_vec++; if (owner !== 3'd1) begin n_err++; $display("FAIL single_owner: got %0d want 1", owner); end
    n_vec++; if (cs_n !== 3'b101) begin n_err++; $display("FAIL single_cs_n: got %b want 101", cs_n); end
    n_vec++; if (spi_mosi !== 1'b1) begin n_err++; $display("FAIL single_mosi: got %b want 1", spi_mosi); end
    n_vec++; if (m_miso !== 3'b010) begin n_err++; $display("FAIL single_miso: got %b want 010", m_miso); end
    m_mosi = '0;
    m_cs_n = '1;
    idle_wait();
  endtask

  task automatic test_fairness;
    logic [2:0] exp_gnt [4];
    int zeros;
    int bad;
    exp_gnt = '{3'b001, 3'b010, 3'b100, 3'b001};
    pulse_reset();
    req   = 3'b111;
    m_sck = 3'b111;
    @(negedge clk);
    n_vec++; if (gnt !== exp_gnt[0]) begin n_err++; $display("FAIL rr_gnt0: got %b want %b", gnt, exp_gnt[0]); end
    for (int i = 1; i < 4; i++) begin
      @(negedge clk);
      req = 3'b111 & ~exp_gnt[i-1];
      @(negedge clk);
      req   = 3'b111;
      zeros = 0;
      bad   = 0;
      while (gnt === 3'b000 && zeros < 20) begin
        zeros++;
        if (spi_sck !== 1'b0 || cs_n !== 3'b111) bad++;
        @(negedge clk);
      end
      n_vec++; if (zeros != GAP + 1) begin n_err++; $display("FAIL rr_gap%0d: got %0d idle cycles want %0d", i, zeros, GAP + 1); end
      n_vec++; if (bad != 0) begin n_err++; $display("FAIL rr_idle_bus%0d: got %0d active cycles want 0", i, bad); end
      n_vec++; if (gnt !== exp_gnt[i]) begin n_err++; $display("FAIL rr_gnt%0d: got %b want %b", i, gnt, exp_gnt[i]); end
    end
    m_sck = '0;
    idle_wait();
  endtask

  task automatic test_no_preempt;
    int bad;
    int waited;
    logic [3:0] jv;
    pulse_reset();
    req      = 3'b001;
    m_cs_n   = 3'b010;
    spi_miso = 1'b1;
    @(negedge clk);
    n_vec++; if (gnt !== 3'b001) begin n_err++; $display("FAIL np_first: got %b want 001", gnt); end
    req = 3'b101;
    bad = 0;
    for (int j = 0; j < 4; j++) begin
      jv    = 4'(j);
      m_sck = {jv[0], 1'b0, jv[1]};
      #1;
      if (gnt !== 3'b001 || cs_n !== 3'b110 || spi_sck !== jv[1] || m_miso !== 3'b001) bad++;
      @(negedge clk);
    end
    n_vec++; if (bad != 0) begin n_err++; $display("FAIL np_hold_gating: got %0d bad cycles want 0", bad); end
    m_sck  = '0;
    req    = 3'b100;
    waited = 0;
    while (gnt !== 3'b100 && waited < 20) begin
      waited++;
      @(negedge clk);
    end
    n_vec++; if (gnt !== 3'b100) begin n_err++; $display("FAIL np_next: got %b want 100", gnt); end
    n_vec++; if (cs_n !== 3'b011) begin n_err++; $display("FAIL np_cs_n: got %b want 011", cs_n); end
    n_vec++; if (m_miso !== 3'b100) begin n_err++; $display("FAIL np_miso: got %b want 100", m_miso); end
    m_cs_n = '1;
    idle_wait();
  endtask

  task automatic test_back_to_back;
    int zeros;
    req = 3'b100;
    @(negedge clk);
    n_vec++; if (gnt !== 3'b100) begin n_err++; $display("FAIL b2b_first: got %b want 100", gnt); end
    req = 3'b000;
    @(negedge clk);
    req   = 3'b100;
    zeros = 0;
    while (gnt === 3'b000 && zeros < 20) begin
      zeros++;
      @(negedge clk);
    end
    n_vec++; if (zeros != GAP + 1) begin n_err++; $display("FAIL b2b_gap: got %0d idle cycles want %0d", zeros, GAP + 1); end
    n_vec++; if (gnt !== 3'b100) begin n_err++; $display("FAIL b2b_regrant: got %b want 100", gnt); end
    idle_wait();
  endtask

  task automatic test_reset_mid_frame;
    req    = 3'b010;
    m_sck  = 3'b010;
    m_cs_n = 3'b101;
    @(negedge clk);
    n_vec++; if (gnt !== 3'b010) begin n_err++; $display("FAIL rst_mid_pre: got %b want 010", gnt); end
    #3;
    enable = 1'b1;
    #1;
    n_vec++; if (gnt !== 3'b000) begin n_err++; $display("FAIL rst_mid_gnt: got %b want 000", gnt); end
    n_vec++; if (cs_n !== 3'b111) begin n_err++; $display("FAIL rst_mid_cs_n: got %b want 111", cs_n); end
    n_vec++; if (spi_sck !== 1'b0) begin n_err++; $display("FAIL rst_mid_sck: got %b want 0", spi_sck); end
    @(negedge clk);
    enable = 1'b0;
    req    = 3'b011;
    m_sck  = '0;
    m_cs_n = '1;
    @(negedge clk);
    n_vec++; if (gnt !== 3'b001) begin n_err++; $display("FAIL rst_mid_next: got %b want 001", gnt); end
    n_vec++; if (owner !== 3'd0) begin n_err++; $display("FAIL rst_mid_owner: got %0d want 0", owner); end
    idle_wait();
  endtask

  task automatic test_timeout;
`ifdef ARB_TIMEOUT_EN
    int ones;
    int regrants;
    int waited;
    req  = 3'b010;
    ones = 0;
    @(negedge clk);
    while (gnt === 3'b010 && ones < 100) begin
      ones++;
      @(negedge clk);
    end
    n_vec++; if (ones != TIMEOUT) begin n_err++; $display("FAIL to_len: got %0d cycles want %0d", ones, TIMEOUT); end
    n_vec++; if (timeout_err !== 1'b1) begin n_err++; $display("FAIL to_flag: got %b want 1", timeout_err); end
    regrants = 0;
    repeat (30) begin
      @(negedge clk);
      if (gnt !== 3'b000) regrants++;
    end
    n_vec++; if (regrants != 0) begin n_err++; $display("FAIL to_masked: got %0d granted cycles want 0", regrants); end
    req = 3'b000;
    @(negedge clk);
    req    = 3'b010;
    waited = 0;
    while (gnt !== 3'b010 && waited < 20) begin
      waited++;
      @(negedge clk);
    end
    n_vec++; if (gnt !== 3'b010) begin n_err++; $display("FAIL to_regrant: got %b want 010", gnt); end
    n_vec++; if (timeout_err !== 1'b1) begin n_err++; $display("FAIL to_sticky: got %b want 1", timeout_err); end
`else
    int bad;
    req = 3'b010;
    bad = 0;
    repeat (3 * TIMEOUT) begin
      @(negedge clk);
      if (gnt !== 3'b010) bad++;
    end
    n_vec++; if (bad != 0) begin n_err++; $display("FAIL no_to_hold: got %0d dropped cycles want 0", bad); end
    n_vec++; if (timeout_err !== 1'b0) begin n_err++; $display("FAIL no_to_flag: got %b want 0", timeout_err); end
`endif
    idle_wait();
  endtask

  initial begin
    test_reset();
    test_single_grant();
    test_fairness();
    test_no_preempt();
    test_back_to_back();
    test_reset_mid_frame();
    test_timeout();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
